// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU address types and call-stack operation decode
package cpu_pkg;

  localparam int ADDR_W     = 8;
  localparam int CALL_DEPTH = 8;

  typedef logic [ADDR_W-1:0] addr_t;

  // One entry per distinct push/pop/occupancy combination the stack reacts to
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_PUSH_FULL,
    OP_POP,
    OP_POP_EMPTY,
    OP_SWAP,
    OP_PUSH_EMPTY_POP
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic do_push, input logic do_pop,
                                          input logic is_full, input logic is_empty);
    if (do_push && do_pop) return is_empty ? OP_PUSH_EMPTY_POP : OP_SWAP;
    if (do_push)           return is_full  ? OP_PUSH_FULL      : OP_PUSH;
    if (do_pop)            return is_empty ? OP_POP_EMPTY      : OP_POP;
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/call_stack_if.sv
// rtl/call_stack_if.sv - decoder-facing CALL/RET bus of the return-address stack
interface call_stack_if #(
  parameter int DEPTH = cpu_pkg::CALL_DEPTH,
  parameter int WIDTH = cpu_pkg::ADDR_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] pc_in;
  logic             err_clr;
  logic [WIDTH-1:0] ret_addr;
  logic             ret_valid;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] depth_cnt;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, pc_in, err_clr,
    input  ret_addr, ret_valid, full, empty, depth_cnt, overflow, underflow
  );

  modport slave (
    input  push, pop, pc_in, err_clr,
    output ret_addr, ret_valid, full, empty, depth_cnt, overflow, underflow
  );
endinterface

// File: rtl/stack_regfile.sv
// rtl/stack_regfile.sv - unreset register array, one sync write port, one comb read port
module stack_regfile #(
  parameter int DEPTH = cpu_pkg::CALL_DEPTH,
  parameter int WIDTH = cpu_pkg::ADDR_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single write port; contents deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/call_stack.sv
// rtl/call_stack.sv - return-address stack; optional sticky flags via CALL_STACK_STATUS_EN
module call_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = CALL_DEPTH,
  parameter int WIDTH = ADDR_W
) (
  input  logic         clk,
  input  logic         reset,
  call_stack_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]    sp;
  logic [CW-1:0]    sp_nxt;
  logic [CW-1:0]    sp_m1;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             we;
  logic             do_ret;
  logic             ov_set;
  logic             un_set;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] ret_addr_q;
  logic             ret_valid_q;
  stack_op_e        op;

  assign full    = (sp == CW'(DEPTH));
  assign empty   = (sp == '0);
  assign sp_m1   = sp - CW'(1);
  assign top_idx = sp_m1[AW-1:0];
  assign op      = decode_op(bus.push, bus.pop, full, empty);

  stack_regfile #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_regfile (
    .clk     (clk),
    .we      (we),
    .wr_idx  (wr_idx),
    .wr_data (bus.pc_in),
    .rd_idx  (top_idx),
    .rd_data (rd_data)
  );

  // Translate the decoded operation into write, pointer and error actions
  always_comb begin
    we     = 1'b0;
    wr_idx = sp[AW-1:0];
    sp_nxt = sp;
    do_ret = 1'b0;
    ov_set = 1'b0;
    un_set = 1'b0;
    case (op)
      OP_PUSH: begin
        we     = 1'b1;
        sp_nxt = sp + CW'(1);
      end
      OP_PUSH_FULL: ov_set = 1'b1;
      OP_POP: begin
        do_ret = 1'b1;
        sp_nxt = sp_m1;
      end
      OP_POP_EMPTY: un_set = 1'b1;
      OP_SWAP: begin
        // Tail call: the returned slot is reused for the new return address
        we     = 1'b1;
        wr_idx = top_idx;
        do_ret = 1'b1;
      end
      OP_PUSH_EMPTY_POP: begin
        we     = 1'b1;
        wr_idx = '0;
        sp_nxt = CW'(1);
        un_set = 1'b1;
      end
      default: ;
    endcase
  end

  // Pointer and the registered return path; reset drops any pending strobe at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp          <= '0;
      ret_addr_q  <= '0;
      ret_valid_q <= 1'b0;
    end else begin
      sp          <= sp_nxt;
      ret_valid_q <= do_ret;
      if (do_ret) ret_addr_q <= rd_data;
    end
  end

`ifdef CALL_STACK_STATUS_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags; a fresh error in the same cycle wins over err_clr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ov_set)           overflow_q  <= 1'b1;
      else if (bus.err_clr) overflow_q  <= 1'b0;
      if (un_set)           underflow_q <= 1'b1;
      else if (bus.err_clr) underflow_q <= 1'b0;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  logic unused_status;
  assign unused_status = ov_set ^ un_set ^ bus.err_clr;
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.ret_addr  = ret_addr_q;
  assign bus.ret_valid = ret_valid_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.depth_cnt = sp;

endmodule

// File: tb/tb_call_stack.sv
// tb/tb_call_stack.sv - queue-model checked bench for call_stack
module tb_call_stack;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
`ifdef CALL_STACK_STATUS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   cmp_en = 1'b0;

  call_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  call_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue whose back is the top of stack
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_ret_addr = '0;
  bit               m_ret_valid = 1'b0;
  bit               m_ov = 1'b0;
  bit               m_un = 1'b0;

  always @(posedge clk or posedge reset) begin
    bit nov, nun;
    if (reset) begin
      q.delete();
      m_ret_addr  = '0;
      m_ret_valid = 1'b0;
      m_ov        = 1'b0;
      m_un        = 1'b0;
    end else begin
      nov = 1'b0;
      nun = 1'b0;
      m_ret_valid = 1'b0;
      if (bus.pop) begin
        if (q.size() > 0) begin
          m_ret_addr  = q.pop_back();
          m_ret_valid = 1'b1;
        end else nun = 1'b1;
      end
      if (bus.push) begin
        if (q.size() < DEPTH) q.push_back(bus.pc_in);
        else nov = 1'b1;
      end
      m_ov = ST & (nov | (m_ov & ~bus.err_clr));
      m_un = ST & (nun | (m_un & ~bus.err_clr));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_ret_valid", 32'(bus.ret_valid), 32'(m_ret_valid));
      check("cmp_ret_addr",  32'(bus.ret_addr),  32'(m_ret_addr));
      check("cmp_depth",     32'(bus.depth_cnt), q.size());
      check("cmp_full",      32'(bus.full),      32'(q.size() == DEPTH));
      check("cmp_empty",     32'(bus.empty),     32'(q.size() == 0));
      check("cmp_overflow",  32'(bus.overflow),  32'(m_ov));
      check("cmp_underflow", 32'(bus.underflow), 32'(m_un));
    end
  end

  task automatic step(input bit p, input bit o, input logic [WIDTH-1:0] d, input bit c);
    bus.push = p; bus.pop = o; bus.pc_in = d; bus.err_clr = c;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.pc_in = '0; bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // Reset / idle state
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_depth", 32'(bus.depth_cnt), 0);
    check("rst_ret_addr", 32'(bus.ret_addr), 0);
    check("rst_ret_valid", 32'(bus.ret_valid), 0);

    // LIFO order with back-to-back pops
    step(1, 0, 8'h10, 0); step(1, 0, 8'h20, 0); step(1, 0, 8'h30, 0);
    step(0, 1, 8'h00, 0);
    check("lifo_0", 32'({bus.ret_valid, bus.ret_addr}), 32'h130);
    step(0, 1, 8'h00, 0);
    check("lifo_1", 32'({bus.ret_valid, bus.ret_addr}), 32'h120);
    step(0, 1, 8'h00, 0);
    check("lifo_2", 32'({bus.ret_valid, bus.ret_addr}), 32'h110);
    idle();
    check("lifo_empty", 32'({bus.empty, bus.ret_valid}), 32'h2);

    // Fill, overflow, pop top
    for (int i = 1; i <= 8; i++) step(1, 0, 8'(i), 0);
    check("fill_full", 32'(bus.full), 1);
    step(1, 0, 8'hFF, 0);
    check("ovf_flag", 32'(bus.overflow), 32'(ST));
    check("ovf_depth", 32'(bus.depth_cnt), 8);
    step(0, 1, 8'h00, 0);
    check("ovf_pop", 32'(bus.ret_addr), 32'h08);
    for (int i = 0; i < 7; i++) step(0, 1, 8'h00, 0);
    check("drain_last", 32'(bus.ret_addr), 32'h01);

    // Underflow, then clear
    step(0, 1, 8'h00, 0);
    check("unf_flag", 32'(bus.underflow), 32'(ST));
    check("unf_no_valid", 32'(bus.ret_valid), 0);
    check("unf_addr_hold", 32'(bus.ret_addr), 32'h01);
    step(0, 0, 8'h00, 1);
    check("clr_flags", 32'({bus.overflow, bus.underflow}), 0);

    // Tail-call swap
    step(1, 0, 8'h11, 0); step(1, 0, 8'h22, 0);
    step(1, 1, 8'h99, 0);
    check("swap_ret", 32'({bus.ret_valid, bus.ret_addr}), 32'h122);
    check("swap_depth", 32'(bus.depth_cnt), 2);
    step(0, 1, 8'h00, 0);
    check("swap_next", 32'(bus.ret_addr), 32'h99);
    step(0, 1, 8'h00, 0);
    check("swap_bottom", 32'(bus.ret_addr), 32'h11);

    // Reset in the middle of a pop strobe
    step(1, 0, 8'h40, 0); step(1, 0, 8'h41, 0);
    step(0, 1, 8'h00, 0);
    check("mid_pop_valid", 32'({bus.ret_valid, bus.ret_addr}), 32'h141);
    bus.pop = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_drop_valid", 32'(bus.ret_valid), 0);
    check("rst_drop_empty", 32'(bus.empty), 1);
    @(negedge clk); reset = 1'b0;
    step(0, 1, 8'h00, 0);
    check("post_rst_unf", 32'(bus.underflow), 32'(ST));
    check("post_rst_nv", 32'(bus.ret_valid), 0);

    // Random traffic, a balanced phase then push-heavy and pop-heavy phases
    for (int i = 0; i < 3000; i++) begin
      int pp;
      pp = (i < 1000) ? 50 : (i < 2000) ? 70 : 30;
      step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < (100 - pp),
           8'($urandom), $urandom_range(0, 99) < 5);
    end

    idle();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
